// File: rtl/seq_csub_pkg.sv
// Shared types and default geometry for the iterative carry-select subtractor.
package seq_csub_pkg;

  localparam int unsigned WIDTH_DEF   = 64;
  localparam int unsigned SLICE_W_DEF = 8;
  localparam int unsigned NSLICE_DEF  = WIDTH_DEF / SLICE_W_DEF;

  // A slice counter needs at least one bit even when there is a single slice.
  function automatic int unsigned idx_w(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

  localparam int unsigned IDX_W_DEF = idx_w(NSLICE_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/csub_slice.sv
// One carry-select subtract slice: a + ~b is formed for both carry-in values, then the
// registered carry picks the result.
module csub_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned WP = W + 1;

  logic [W:0] s0;
  logic [W:0] s1;

  assign s0 = {1'b0, a} + {1'b0, ~b};
  assign s1 = {1'b0, a} + {1'b0, ~b} + WP'(1);

  assign sum  = cin ? s1[W-1:0] : s0[W-1:0];
  assign cout = cin ? s1[W]     : s0[W];

endmodule

// File: rtl/seq_csub_64.sv
// Iterative subtractor: diff = a - b - bin, one SLICE_W-bit slice per cycle with the
// inter-slice carry held in a register; valid/ready on both sides.
module seq_csub_64
  import seq_csub_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SLICE_W = SLICE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = idx_w(NSLICE);
  localparam int unsigned MSB    = WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bout_q;
  logic               ovf_q;
  logic               zero_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] sum_sl;
  logic               cout_sl;
  logic [WIDTH-1:0]   diff_d;

  // Select the active operand slices and splice the new slice sum into the result.
  always_comb begin
    a_sl   = a_q[idx_q*SLICE_W +: SLICE_W];
    b_sl   = b_q[idx_q*SLICE_W +: SLICE_W];
    diff_d = diff_q;
    diff_d[idx_q*SLICE_W +: SLICE_W] = sum_sl;
  end

  csub_slice #(
    .W (SLICE_W)
  ) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (sum_sl),
    .cout (cout_sl)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          // Operands are only sampled on a real handshake, so idle X never reaches state.
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= ~bin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          diff_q  <= diff_d;
          carry_q <= cout_sl;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            bout_q      <= ~cout_sl;
            ovf_q       <= (a_q[MSB] != b_q[MSB]) && (diff_d[MSB] != a_q[MSB]);
            zero_q      <= (diff_d == '0);
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Ready returns with consumption so the next accept lands one cycle later.
          if (out_ready && out_valid_q) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/seq_csub_64.md
Name: seq_csub_64

Overview:
- Iterative 64-bit unsigned/two's-complement subtractor computing diff = a - b - bin.
- Processes one SLICE_W-bit slice per cycle through a single carry-select slice; the inter-slice borrow is held in a register.
- valid/ready handshake on input and output.
- Used where area matters more than the single-cycle registered adder's latency; it is the inverse-operation companion of that adder in the arithmetic library.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of SLICE_W.
- SLICE_W, 8, bits processed per cycle; NSLICE = WIDTH/SLICE_W (8 by default).

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- a, input, WIDTH, minuend; sampled on input handshake.
- b, input, WIDTH, subtrahend; sampled on input handshake.
- bin, input, 1, borrow-in; sampled on input handshake.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, block can accept operands.
- diff, output, WIDTH, result a - b - bin mod 2^WIDTH.
- bout, output, 1, borrow-out; 1 iff a < b + bin, unsigned.
- ovf, output, 1, signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- zero, output, 1, diff == 0.
- out_valid, output, 1, diff, bout, ovf and zero are valid.
- out_ready, input, 1, consumer accepts the result.

Behaviour:
- Arithmetic: diff = a + ~b + carry, where initial carry = ~bin and bout = ~(final carry).
- Reset (rst=0, async): state=IDLE, slice index=0, operand and result registers=0, carry=0, diff=0, bout=0, ovf=0, zero=0, out_valid=0, in_ready=0 while rst is asserted. in_ready rises in the first cycle after rst deasserts.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid && in_ready at a posedge: latch a, b and carry=~bin; idx=0; go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each cycle: slice idx of the result register gets the slice sum of a_slice + ~b_slice with the registered carry; carry takes the slice carry-out; idx increments.
  - When idx==NSLICE-1, also compute bout, ovf and zero from the final values, then go to DONE.
  - CALC lasts exactly NSLICE cycles.
- DONE:
  - out_valid=1, in_ready=0; all outputs held stable.
  - out_valid && out_ready at a posedge: go to IDLE, out_valid drops next cycle.
  - No new operand is accepted in the same cycle as result consumption; the next accept is possible one cycle later.
- Latency: accept edge at T gives out_valid=1 from T+NSLICE (8 edges later) until handshake.
- Throughput: one operation per NSLICE+2 cycles with out_ready held high.
- in_valid outside IDLE is ignored; the operand is not consumed.
- Backpressure: out_ready low holds DONE indefinitely; diff, bout, ovf and zero must not change.
- diff keeps the last result after return to IDLE (out_valid=0); it is overwritten slice-by-slice in CALC.
- Reset mid-CALC or mid-DONE: immediate abort; all outputs go to reset values; the partial result is lost.
- X on a, b or bin when not handshaking must not propagate into state.

Decomposition:
- Package seq_csub_pkg holds:
  - the state enum (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the defaults for WIDTH and SLICE_W;
  - the derived NSLICE and index width $clog2(NSLICE).
- Sub-module csub_slice (SLICE_W-bit, combinational) computes a + ~b for both carry-in values in parallel and selects with the registered carry. It mirrors the library's carry-select structure and outputs the slice sum and carry-out.
- The top-level FSM, index counter and registers live in seq_csub_64.

Test Plan:
- a=10, b=5, bin=0 -> 8 cycles after accept: diff=5, bout=0, ovf=0, zero=0.
- a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0, zero=0.
- a=0x8000_0000_0000_0000, b=1, bin=0 -> diff=0x7FFF_FFFF_FFFF_FFFF, bout=0, ovf=1.
- a=5, b=5, bin=1 -> diff=all ones, bout=1; then a=b=0x1234_5678_9ABC_DEF0, bin=0 -> diff=0, zero=1, bout=0.
- Backpressure: out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next cycle, and the next operand is accepted the cycle after.
- rst=0 at cycle 4 of CALC (asynchronous, mid-cycle) -> out_valid=0 and diff=0 immediately. After release: in_ready=1 next cycle; a fresh 7-3 gives diff=4 with correct latency.
